// File: rtl/data_memory_pkg.sv
// Shared encodings, FSM state type and byte-lane helpers for the data_memory block.
package data_memory_pkg;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;
  localparam logic [1:0] WIDTH_RSVD = 2'b11;

  // Bytes touched per width code; the reserved code is rejected before use.
  localparam logic [2:0] WIDTH_BYTES [4] = '{3'd1, 3'd2, 3'd4, 3'd4};

  typedef enum logic {
    IDLE,
    SECOND
  } state_t;

  function automatic logic [31:0] rotl_bytes(input logic [31:0] d, input logic [1:0] off);
    logic [63:0] t;
    t = {d, d} << {off, 3'b000};
    return t[63:32];
  endfunction

  function automatic logic [31:0] rotr_bytes(input logic [31:0] d, input logic [1:0] off);
    logic [63:0] t;
    t = {d, d} >> {off, 3'b000};
    return t[31:0];
  endfunction

  // Lanes of the starting row covered by an access of nbytes at offset off.
  function automatic logic [3:0] first_lanes(input logic [1:0] off, input logic [2:0] nbytes);
    logic [3:0] m;
    logic [3:0] lo;
    logic [3:0] hi;
    lo = {2'b00, off};
    hi = lo + {1'b0, nbytes};
    for (int l = 0; l < 4; l++) begin
      m[l] = (4'(l) >= lo) && (4'(l) < hi);
    end
    return m;
  endfunction

  function automatic logic [3:0] second_lanes(input logic [1:0] off, input logic [2:0] nbytes);
    logic [3:0] m;
    logic [3:0] hi;
    hi = {2'b00, off} + {1'b0, nbytes};
    for (int l = 0; l < 4; l++) begin
      m[l] = (4'(l) + 4'd4) < hi;
    end
    return m;
  endfunction

endpackage

// File: rtl/data_memory_lane.sv
// One byte lane of the data RAM: DEPTH x 8 storage, write enable, registered read.
module data_memory_lane #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Read data only updates on an enabled read so untouched lanes keep earlier bytes.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/data_memory.sv
// Byte-addressable data RAM responder with byte/half/word access and load extension.
// DATA_MEMORY_MISALIGNED_EN enables misaligned accesses (row-crossing ones take two cycles).
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [1:0]  i_width,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  output logic        o_ready,
  output logic        o_valid,
  output logic [31:0] o_rdata,
  output logic        o_illegal
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [2:0]      req_bytes;
  logic [32:0]     last_addr;
  logic [AW-1:0]   req_row;
  logic            misalign_bad;
  logic            req_cross;
  logic            req_illegal;
  logic            accept;
  logic            in_second;

  logic [1:0]      rsp_width;
  logic [1:0]      rsp_off;
  logic            rsp_unsigned;
  logic            rsp_load;

  logic [3:0]      lane_en;
  logic            lane_we;
  logic [AW-1:0]   lane_row;
  logic [3:0][7:0] lane_wdata;
  logic [3:0][7:0] lane_rdata;
  logic [31:0]     load_word;

  assign req_bytes = WIDTH_BYTES[i_width];
  assign last_addr = {1'b0, i_addr} + {30'd0, req_bytes} - 33'd1;
  assign req_row   = i_addr[AW+1:2];
  assign o_ready   = !rst && !in_second;
  assign accept    = i_req && o_ready;

`ifdef DATA_MEMORY_MISALIGNED_EN
  state_t          state;
  logic [AW-1:0]   cap_row;
  logic [31:0]     cap_wdata;
  logic            cap_we;

  assign misalign_bad = 1'b0;
  assign req_cross    = ({1'b0, i_addr[1:0]} + req_bytes) > 3'd4;
  assign in_second    = (state == SECOND);
`else
  assign misalign_bad = ((i_width == WIDTH_HALF) && i_addr[0]) ||
                        ((i_width == WIDTH_WORD) && (i_addr[1:0] != 2'b00));
  assign req_cross    = 1'b0;
  assign in_second    = 1'b0;
`endif

  // last_addr is 33 bits wide so accesses wrapping past 0xFFFFFFFF are still caught.
  assign req_illegal = (i_width == WIDTH_RSVD) || (last_addr >= 33'(DEPTH * 4)) || misalign_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid      <= 1'b0;
      o_illegal    <= 1'b0;
      rsp_width    <= WIDTH_BYTE;
      rsp_off      <= 2'b00;
      rsp_unsigned <= 1'b0;
      rsp_load     <= 1'b0;
`ifdef DATA_MEMORY_MISALIGNED_EN
      state        <= IDLE;
      cap_row      <= '0;
      cap_wdata    <= '0;
      cap_we       <= 1'b0;
`endif
    end else begin
      o_valid   <= 1'b0;
      o_illegal <= 1'b0;
      if (accept) begin
        rsp_width    <= i_width;
        rsp_off      <= i_addr[1:0];
        rsp_unsigned <= i_unsigned;
        rsp_load     <= !i_we && !req_illegal;
        o_illegal    <= req_illegal;
        o_valid      <= req_illegal || !req_cross;
`ifdef DATA_MEMORY_MISALIGNED_EN
        if (!req_illegal && req_cross) begin
          state     <= SECOND;
          cap_row   <= req_row + 1'b1;
          cap_wdata <= i_wdata;
          cap_we    <= i_we;
        end
`endif
      end
`ifdef DATA_MEMORY_MISALIGNED_EN
      else if (state == SECOND) begin
        state   <= IDLE;
        o_valid <= 1'b1;
      end
`endif
    end
  end

  // In SECOND the lanes below the starting offset are accessed one row higher.
  always_comb begin
    lane_row   = req_row;
    lane_we    = i_we;
    lane_wdata = rotl_bytes(i_wdata, i_addr[1:0]);
    lane_en    = (accept && !req_illegal) ? first_lanes(i_addr[1:0], req_bytes) : 4'b0000;
`ifdef DATA_MEMORY_MISALIGNED_EN
    if (in_second) begin
      lane_row   = cap_row;
      lane_we    = cap_we;
      lane_wdata = rotl_bytes(cap_wdata, rsp_off);
      lane_en    = second_lanes(rsp_off, WIDTH_BYTES[rsp_width]);
    end
`endif
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    data_memory_lane #(
      .DEPTH(DEPTH),
      .AW   (AW)
    ) u_lane (
      .clk  (clk),
      .en   (lane_en[g]),
      .we   (lane_we),
      .addr (lane_row),
      .wdata(lane_wdata[g]),
      .rdata(lane_rdata[g])
    );
  end

  always_comb begin
    load_word = rotr_bytes(lane_rdata, rsp_off);
    o_rdata   = 32'd0;
    if (o_valid && rsp_load) begin
      case (rsp_width)
        WIDTH_BYTE: o_rdata = {{24{!rsp_unsigned && load_word[7]}}, load_word[7:0]};
        WIDTH_HALF: o_rdata = {{16{!rsp_unsigned && load_word[15]}}, load_word[15:0]};
        default:    o_rdata = load_word;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory; covers both DATA_MEMORY_MISALIGNED_EN builds.
module tb_data_memory;
  import data_memory_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic        i_we;
  logic [31:0] i_addr;
  logic [1:0]  i_width;
  logic        i_unsigned;
  logic [31:0] i_wdata;
  logic        o_ready;
  logic        o_valid;
  logic [31:0] o_rdata;
  logic        o_illegal;

  int errors = 0;
  int checks = 0;

`ifdef DATA_MEMORY_MISALIGNED_EN
  localparam logic [31:0] EXP_WORD_10 = 32'h12341122;
`else
  localparam logic [31:0] EXP_WORD_10 = 32'h12345AEF;
`endif

  always #5 clk = ~clk;

  data_memory #(.DEPTH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_we      (i_we),
    .i_addr    (i_addr),
    .i_width   (i_width),
    .i_unsigned(i_unsigned),
    .i_wdata   (i_wdata),
    .o_ready   (o_ready),
    .o_valid   (o_valid),
    .o_rdata   (o_rdata),
    .o_illegal (o_illegal)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Presents one request from a point just after a rising edge; returns in the response cycle.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [1:0] width,
                               input logic uns, input logic [31:0] wdata);
    i_req      = 1'b1;
    i_we       = we;
    i_addr     = addr;
    i_width    = width;
    i_unsigned = uns;
    i_wdata    = wdata;
    @(posedge clk);
    #1;
    i_req = 1'b0;
  endtask

  task automatic checkResponse(input string tag, input logic ill, input logic [31:0] data);
    checkOutput({tag, " valid"}, 32'(o_valid), 32'd1);
    checkOutput({tag, " illegal"}, 32'(o_illegal), 32'(ill));
    checkOutput({tag, " rdata"}, o_rdata, data);
  endtask

  task automatic idleCycle(input string tag);
    @(posedge clk);
    #1;
    checkOutput({tag, " pulse"}, 32'(o_valid), 32'd0);
    checkOutput({tag, " ready"}, 32'(o_ready), 32'd1);
  endtask

  function automatic logic [31:0] pattern(input int i);
    return {8'(i), 8'hC3, 8'(8'hF0 ^ 8'(i)), 8'h3C};
  endfunction

  initial begin
    rst = 1'b0;
    i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_width = WIDTH_WORD; i_unsigned = 1'b0; i_wdata = '0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset ready", 32'(o_ready), 32'd0);
    checkOutput("reset valid", 32'(o_valid), 32'd0);
    checkOutput("reset illegal", 32'(o_illegal), 32'd0);
    checkOutput("reset rdata", o_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("ready after release", 32'(o_ready), 32'd1);
    @(posedge clk);
    #1;

    // Basic store, read-after-write and extension variants
    applyStimulus(1'b1, 32'h10, WIDTH_WORD, 1'b0, 32'hDEADBEEF);
    checkResponse("sw 0x10", 1'b0, 32'd0);
    checkOutput("ready during valid", 32'(o_ready), 32'd1);
    applyStimulus(1'b0, 32'h10, WIDTH_WORD, 1'b0, 32'd0);
    checkResponse("lw 0x10 raw", 1'b0, 32'hDEADBEEF);
    applyStimulus(1'b0, 32'h13, WIDTH_BYTE, 1'b0, 32'd0);
    checkResponse("lb 0x13", 1'b0, 32'hFFFFFFDE);
    applyStimulus(1'b0, 32'h13, WIDTH_BYTE, 1'b1, 32'd0);
    checkResponse("lbu 0x13", 1'b0, 32'h000000DE);
    applyStimulus(1'b0, 32'h12, WIDTH_HALF, 1'b0, 32'd0);
    checkResponse("lh 0x12", 1'b0, 32'hFFFFDEAD);
    applyStimulus(1'b0, 32'h10, WIDTH_HALF, 1'b1, 32'd0);
    checkResponse("lhu 0x10", 1'b0, 32'h0000BEEF);
    applyStimulus(1'b0, 32'h11, WIDTH_BYTE, 1'b0, 32'd0);
    checkResponse("lb 0x11", 1'b0, 32'hFFFFFFBE);
    applyStimulus(1'b0, 32'h10, WIDTH_BYTE, 1'b1, 32'd0);
    checkResponse("lbu 0x10", 1'b0, 32'h000000EF);
    applyStimulus(1'b0, 32'h10, WIDTH_WORD, 1'b1, 32'd0);
    checkResponse("lw unsigned ignored", 1'b0, 32'hDEADBEEF);
    idleCycle("after loads");

    // Partial stores touch only their lanes
    applyStimulus(1'b1, 32'h11, WIDTH_BYTE, 1'b0, 32'hFFFFFF5A);
    checkResponse("sb 0x11", 1'b0, 32'd0);
    applyStimulus(1'b0, 32'h10, WIDTH_WORD, 1'b0, 32'd0);
    checkResponse("lw after sb", 1'b0, 32'hDEAD5AEF);
    applyStimulus(1'b1, 32'h12, WIDTH_HALF, 1'b0, 32'hAAAA1234);
    checkResponse("sh 0x12", 1'b0, 32'd0);
    applyStimulus(1'b0, 32'h10, WIDTH_WORD, 1'b0, 32'd0);
    checkResponse("lw after sh", 1'b0, 32'h12345AEF);

    // Illegal requests: range, reserved width, address wrap
    applyStimulus(1'b0, 32'h100, WIDTH_WORD, 1'b0, 32'd0);
    checkResponse("lw 0x100", 1'b1, 32'd0);
    idleCycle("illegal single pulse");
    applyStimulus(1'b1, 32'h100, WIDTH_WORD, 1'b0, 32'h55555555);
    checkResponse("sw 0x100", 1'b1, 32'd0);
    applyStimulus(1'b1, 32'h110, WIDTH_BYTE, 1'b0, 32'h00000077);
    checkResponse("sb 0x110", 1'b1, 32'd0);
    applyStimulus(1'b1, 32'h10, WIDTH_RSVD, 1'b0, 32'h00000000);
    checkResponse("store width 11", 1'b1, 32'd0);
    applyStimulus(1'b0, 32'h10, WIDTH_RSVD, 1'b0, 32'd0);
    checkResponse("load width 11", 1'b1, 32'd0);
    applyStimulus(1'b0, 32'h10, WIDTH_WORD, 1'b0, 32'd0);
    checkResponse("lw 0x10 unchanged", 1'b0, 32'h12345AEF);

    // Top-of-memory boundary
    applyStimulus(1'b1, 32'hFC, WIDTH_WORD, 1'b0, 32'hCAFEF00D);
    checkResponse("sw 0xFC", 1'b0, 32'd0);
    applyStimulus(1'b0, 32'hFC, WIDTH_WORD, 1'b0, 32'd0);
    checkResponse("lw 0xFC", 1'b0, 32'hCAFEF00D);
    applyStimulus(1'b0, 32'hFF, WIDTH_BYTE, 1'b1, 32'd0);
    checkResponse("lbu 0xFF", 1'b0, 32'h000000CA);
    applyStimulus(1'b0, 32'hFE, WIDTH_HALF, 1'b0, 32'd0);
    checkResponse("lh 0xFE", 1'b0, 32'hFFFFCAFE);
    applyStimulus(1'b0, 32'hFD, WIDTH_WORD, 1'b0, 32'd0);
    checkResponse("lw 0xFD", 1'b1, 32'd0);
    applyStimulus(1'b0, 32'hFF, WIDTH_HALF, 1'b0, 32'd0);
    checkResponse("lh 0xFF", 1'b1, 32'd0);
    applyStimulus(1'b0, 32'hFFFFFFFC, WIDTH_WORD, 1'b0, 32'd0);
    checkResponse("lw wrap", 1'b1, 32'd0);

    // Misaligned and row-crossing accesses
    applyStimulus(1'b1, 32'h0C, WIDTH_WORD, 1'b0, 32'h00000000);
    checkResponse("sw 0x0C", 1'b0, 32'd0);
    applyStimulus(1'b1, 32'h0E, WIDTH_WORD, 1'b0, 32'h11223344);
`ifdef DATA_MEMORY_MISALIGNED_EN
    checkOutput("cross sw wait valid", 32'(o_valid), 32'd0);
    checkOutput("cross sw wait ready", 32'(o_ready), 32'd0);
    i_req = 1'b1; i_we = 1'b1; i_addr = 32'h10; i_width = WIDTH_WORD; i_wdata = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    i_req = 1'b0;
    checkResponse("cross sw 0x0E", 1'b0, 32'd0);
    checkOutput("cross sw ready after", 32'(o_ready), 32'd1);
    applyStimulus(1'b0, 32'h0C, WIDTH_WORD, 1'b0, 32'd0);
    checkResponse("lw 0x0C after cross", 1'b0, 32'h33440000);
    applyStimulus(1'b0, 32'h10, WIDTH_WORD, 1'b0, 32'd0);
    checkResponse("lw 0x10 after cross", 1'b0, EXP_WORD_10);
    applyStimulus(1'b0, 32'h11, WIDTH_HALF, 1'b1, 32'd0);
    checkResponse("lhu 0x11 in-row", 1'b0, 32'h00003411);
    applyStimulus(1'b0, 32'h0E, WIDTH_WORD, 1'b0, 32'd0);
    checkOutput("cross lw wait valid", 32'(o_valid), 32'd0);
    @(posedge clk);
    #1;
    checkResponse("cross lw 0x0E", 1'b0, 32'h11223344);
    applyStimulus(1'b0, 32'h0F, WIDTH_HALF, 1'b0, 32'd0);
    checkOutput("cross lh wait ready", 32'(o_ready), 32'd0);
    @(posedge clk);
    #1;
    checkResponse("cross lh 0x0F", 1'b0, 32'h00002233);
    idleCycle("after cross");

    // Reset during SECOND aborts the access
    applyStimulus(1'b0, 32'h0E, WIDTH_WORD, 1'b0, 32'd0);
    checkOutput("abort second ready", 32'(o_ready), 32'd0);
    rst = 1'b1;
`else
    checkResponse("misaligned sw 0x0E", 1'b1, 32'd0);
    applyStimulus(1'b0, 32'h0C, WIDTH_WORD, 1'b0, 32'd0);
    checkResponse("lw 0x0C untouched", 1'b0, 32'h00000000);
    applyStimulus(1'b0, 32'h10, WIDTH_WORD, 1'b0, 32'd0);
    checkResponse("lw 0x10 untouched", 1'b0, EXP_WORD_10);
    applyStimulus(1'b0, 32'h11, WIDTH_HALF, 1'b1, 32'd0);
    checkResponse("lhu 0x11 misaligned", 1'b1, 32'd0);
    applyStimulus(1'b0, 32'h0E, WIDTH_WORD, 1'b0, 32'd0);
    checkResponse("lw 0x0E misaligned", 1'b1, 32'd0);
    applyStimulus(1'b0, 32'h12, WIDTH_HALF, 1'b0, 32'd0);
    checkResponse("lh 0x12 aligned", 1'b0, 32'h00001234);
    idleCycle("after misaligned");

    // Reset in a response cycle clears the pending pulse
    applyStimulus(1'b0, 32'h10, WIDTH_WORD, 1'b0, 32'd0);
    checkOutput("pre-reset valid", 32'(o_valid), 32'd1);
    rst = 1'b1;
`endif
    #1;
    checkOutput("mid reset valid", 32'(o_valid), 32'd0);
    checkOutput("mid reset ready", 32'(o_ready), 32'd0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post reset no valid", 32'(o_valid), 32'd0);
    checkOutput("post reset ready", 32'(o_ready), 32'd1);
    idleCycle("post reset quiet");
    applyStimulus(1'b0, 32'h10, WIDTH_WORD, 1'b0, 32'd0);
    checkResponse("lw after abort", 1'b0, EXP_WORD_10);

    // 16 back-to-back stores followed by 16 back-to-back loads
    i_req = 1'b1;
    for (int i = 0; i < 32; i++) begin
      i_we    = (i < 16);
      i_addr  = 32'h40 + 32'(4 * (i % 16));
      i_width = WIDTH_WORD;
      i_wdata = pattern(i % 16);
      @(posedge clk);
      #1;
      checkOutput("b2b valid", 32'(o_valid), 32'd1);
      checkOutput("b2b ready", 32'(o_ready), 32'd1);
      checkOutput("b2b rdata", o_rdata, (i < 16) ? 32'd0 : pattern(i % 16));
    end
    i_req = 1'b0;
    idleCycle("b2b end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
